kf_spike_eject: RTL and testbench
=================================

Name: kf_spike_eject

Overview:
- NoC ejection endpoint of a Kitten Fabric tile.
- Consumes 32-bit spike flits from the tile router and filters them by destination tile.
- Buffers valid spikes and drives them into the SNN core's spike input port (spike_in_valid/ready/pre_id/payload) with a strict valid/ready transmitter discipline.
- The core accepts spikes only when idle, so this block absorbs router bursts while the core walks synapse ranges.

Parameters:
FIFO_DEPTH, 8, buffer entries behind the output register; power of two, >=2
NEURON_ID_BITS, KF_NEURON_ID_BITS, presynaptic id width; must be <=14
TILE_ID_BITS, 8, tile id width (flit field is 8 bits)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flit_in_valid  input  1  router flit valid
flit_in_ready  output  1  block accepts flit this cycle
flit_in_data  input  32  flit: [31:30] type, [29:22] dest tile, [21:8] pre_id field, [7:0] payload
my_tile_id  input  TILE_ID_BITS  this tile's id; quasi-static, sampled per flit
spike_valid  output  1  to core spike_in_valid
spike_ready  input  1  from core spike_in_ready
spike_pre_id  output  NEURON_ID_BITS  to core spike_in_pre_id
spike_payload  output  8  to core spike_in_payload
drop_count  output  16  saturating count of discarded flits
level  output  $clog2(FIFO_DEPTH+1)+1  spikes held (FIFO + output register)
busy  output  1  level != 0

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - spike_valid=0, spike_pre_id=0, spike_payload=0
  - drop_count=0, level=0, busy=0
  - all FIFO entries invalidated; pointers=0
  - flit_in_ready=1 from the first cycle after reset.
- Reset asserted mid-operation flushes all queued spikes. No partial spike is emitted.
- Accept: a flit is taken on an edge where flit_in_valid && flit_in_ready.
- flit_in_ready = !fifo_full. It is combinational from the registered count and does not depend on flit type or flit_in_valid.
- Decode at acceptance:
  - type 2'b01 SPIKE: if dest==my_tile_id and pre_id field bits [13:NEURON_ID_BITS] are all zero, enqueue {pre_id, payload}. Otherwise discard and increment drop_count.
  - type 2'b00 NOP: consumed silently.
  - type 2'b10 TIMESTEP: see Optional Feature.
  - type 2'b11 reserved: discard and increment drop_count.
- drop_count saturates at 16'hFFFF.
- Storage: output register plus FIFO_DEPTH-entry FIFO. Total capacity is FIFO_DEPTH+1.
- Enqueue path:
  - If the output register is empty (or being drained this edge) and the FIFO is empty, the spike loads the output register directly.
  - Latency is then 1 cycle: spike_valid is high the cycle after acceptance.
  - Otherwise the spike is written to the FIFO.
- Drain: on spike_valid && spike_ready, the output register reloads from the FIFO head on the same edge if the FIFO is non-empty, else it clears. Back-to-back spikes every cycle are sustained while spike_ready=1.
- Hold rule: while spike_valid=1 && spike_ready=0, spike_pre_id and spike_payload are stable. spike_valid never deasserts without a handshake, except on reset.
- Ordering: spikes leave in acceptance order.
- Simultaneous enqueue and drain in the same cycle leaves level unchanged.
- Full condition: flit_in_ready=0 only when the FIFO is full. The output register may additionally hold one spike, giving a maximum level of FIFO_DEPTH+1.
- Pointers carry an extra wrap bit; full/empty are distinguished by the MSB.
- level updates on the same edge as push/pop.

Optional Feature:
- Macro: KF_SPIKE_EJECT_TSTAMP_EN.
- Defined:
  - An 8-bit timestep counter (reset 0) increments by 1 on each accepted TIMESTEP flit addressed to my_tile_id, wrapping 8'hFF->8'h00.
  - Enqueued spikes carry the counter value in place of the flit payload. A TIMESTEP flit and a SPIKE flit are never accepted in the same cycle, so there is no ordering hazard.
  - A TIMESTEP flit addressed to another tile increments drop_count.
- Undefined: TIMESTEP flits are consumed silently with no counter, and payload passes through unchanged.

Test Plan:
- Single spike: my_tile_id=3, flit type 01/dest 3/pre_id 5/payload 8'hA5, spike_ready=1 -> spike_valid high exactly one cycle, one cycle after acceptance, pre_id=5, payload=A5; level returns to 0.
- Backpressure, FIFO_DEPTH=8: spike_ready=0, offer 10 spikes pre_id 0..9 -> 9 accepted, flit_in_ready=0 after the 9th, level=9, outputs held at pre_id 0; then spike_ready=1 -> ids 0..9 emitted in order on consecutive cycles.
- Filtering: flits with dest 4 (my_tile_id=3), type 11, and pre_id field with an out-of-range upper bit set -> no spike_valid, drop_count=3; NOP -> drop_count unchanged.
- Throughput/order: continuous spike stream with spike_ready toggling 1,0,1,0 -> no loss, no duplication, order preserved, level never exceeds 9.
- Reset mid-operation: 5 spikes queued, rst high 1 cycle -> next cycle spike_valid=0, level=0, drop_count=0; a subsequent spike is delivered with 1-cycle latency.
- Optional feature: 3 TIMESTEP flits to tile 3, then spike with payload 8'h11 -> payload 8'h03 with KF_SPIKE_EJECT_TSTAMP_EN, 8'h11 without.

Source files
------------

// File: rtl/kf_spike_eject.sv
// -----------------------------------------------------------------------------
// kf_spike_eject
// NoC ejection endpoint of a Kitten Fabric tile. Takes 32-bit flits from the
// tile router, keeps only the spikes addressed to this tile, and feeds them to
// the SNN core's spike input port. A FIFO behind the output register absorbs
// router bursts while the core is busy walking synapse ranges.
//
// Optional feature macro: KF_SPIKE_EJECT_TSTAMP_EN
//   When defined, TIMESTEP flits addressed to this tile advance an 8-bit
//   counter, and enqueued spikes carry that counter in place of the payload.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flit_in_valid    router flit valid
//   flit_in_ready    flit accepted this cycle (low only while the FIFO is full)
//   flit_in_data     [31:30] type, [29:22] dest tile, [21:8] pre_id, [7:0] payload
//   my_tile_id       this tile's id (quasi-static)
//   spike_valid      spike to the core (valid/ready, held until handshake)
//   spike_ready      core accepts the spike
//   spike_pre_id     presynaptic neuron id
//   spike_payload    spike payload (or timestep with the optional feature)
//   drop_count       saturating count of discarded flits
//   level            spikes held (FIFO + output register)
//   busy             level != 0
// -----------------------------------------------------------------------------
module kf_spike_eject #(
    parameter int FIFO_DEPTH     = 8,
    parameter int NEURON_ID_BITS = 10,
    parameter int TILE_ID_BITS   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flit_in_valid,
    output logic                                  flit_in_ready,
    input  logic [31:0]                           flit_in_data,
    input  logic [TILE_ID_BITS-1:0]               my_tile_id,
    output logic                                  spike_valid,
    input  logic                                  spike_ready,
    output logic [NEURON_ID_BITS-1:0]             spike_pre_id,
    output logic [7:0]                            spike_payload,
    output logic [15:0]                           drop_count,
    output logic [$clog2(FIFO_DEPTH+1):0]         level,
    output logic                                  busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        FT_NOP    = 2'b00,
        FT_SPIKE  = 2'b01,
        FT_TSTAMP = 2'b10,
        FT_RSVD   = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic [NEURON_ID_BITS-1:0] pre_id;
        logic [7:0]                payload;
    } spike_t;

    spike_t             mem [FIFO_DEPTH];
    spike_t             out_q;
    logic               out_valid_q;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic [15:0]        drop_q;
`ifdef KF_SPIKE_EJECT_TSTAMP_EN
    logic [7:0]         tstep_q;
`endif

    // Flit fields
    flit_type_t               ftype;
    logic [TILE_ID_BITS-1:0]  fdest;
    logic [13:0]              fpre;
    logic [7:0]               fpay;

    logic   fifo_empty, fifo_full;
    logic   accept, pop, enq, drop, load_direct, fifo_wr;
    logic   dest_match, id_ok;
    spike_t new_spike;

    // Wrap bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign flit_in_ready = !fifo_full;

    assign accept = flit_in_valid && flit_in_ready;
    assign pop    = out_valid_q && spike_ready;

    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ftype      = flit_type_t'(flit_in_data[31:30]);
        fdest      = TILE_ID_BITS'(flit_in_data[29:22]);
        fpre       = flit_in_data[21:8];
        fpay       = flit_in_data[7:0];
        dest_match = (fdest == my_tile_id);
        // Ids wider than the core's neuron space cannot be addressed.
        id_ok      = ((fpre >> NEURON_ID_BITS) == 14'd0);

        new_spike.pre_id = fpre[NEURON_ID_BITS-1:0];
`ifdef KF_SPIKE_EJECT_TSTAMP_EN
        new_spike.payload = tstep_q;
`else
        new_spike.payload = fpay;
`endif

        enq  = accept && (ftype == FT_SPIKE) && dest_match && id_ok;
        drop = accept && (((ftype == FT_SPIKE) && !(dest_match && id_ok)) ||
                          (ftype == FT_RSVD)
`ifdef KF_SPIKE_EJECT_TSTAMP_EN
                          || ((ftype == FT_TSTAMP) && !dest_match)
`endif
                         );

        // Bypass the FIFO only when doing so cannot overtake queued spikes.
        load_direct = enq && fifo_empty && (!out_valid_q || pop);
        fifo_wr     = enq && !load_direct;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            drop_q      <= '0;
`ifdef KF_SPIKE_EJECT_TSTAMP_EN
            tstep_q     <= '0;
`endif
        end else begin
            if (pop) begin
                if (!fifo_empty) begin
                    out_q  <= mem[rd_ptr[AW-1:0]];
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end else if (load_direct) begin
                    out_q  <= new_spike;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (load_direct) begin
                out_valid_q <= 1'b1;
                out_q       <= new_spike;
            end

            if (fifo_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);

            case ({enq, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase

            if (drop && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;

`ifdef KF_SPIKE_EJECT_TSTAMP_EN
            if (accept && (ftype == FT_TSTAMP) && dest_match)
                tstep_q <= tstep_q + 8'd1;
`endif
        end
    end

    // NOTE: the storage array has no reset; entries are only meaningful between
    // the pointers, and resetting the pointers invalidates them all.
    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr[AW-1:0]] <= new_spike;
    end

    assign spike_valid   = out_valid_q;
    assign spike_pre_id  = out_q.pre_id;
    assign spike_payload = out_q.payload;
    assign drop_count    = drop_q;
    assign level         = level_q;
    assign busy          = (level_q != '0);

endmodule

// File: tb/tb_kf_spike_eject.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for kf_spike_eject (FIFO_DEPTH=8,
// NEURON_ID_BITS=10). Inputs change 1 time unit after a rising edge and
// outputs are sampled there as well, away from the active edge.
// -----------------------------------------------------------------------------
module tb_kf_spike_eject;

    logic        clk = 1'b0;
    logic        rst;
    logic        flit_in_valid;
    logic        flit_in_ready;
    logic [31:0] flit_in_data;
    logic [7:0]  my_tile_id;
    logic        spike_valid;
    logic        spike_ready;
    logic [9:0]  spike_pre_id;
    logic [7:0]  spike_payload;
    logic [15:0] drop_count;
    logic [4:0]  level;
    logic        busy;

    int passed = 0;
    int total  = 0;

    kf_spike_eject #(
        .FIFO_DEPTH    (8),
        .NEURON_ID_BITS(10),
        .TILE_ID_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .flit_in_data (flit_in_data),
        .my_tile_id   (my_tile_id),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_pre_id (spike_pre_id),
        .spike_payload(spike_payload),
        .drop_count   (drop_count),
        .level        (level),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] d,
                                       input logic [13:0] p, input logic [7:0] y);
        return {t, d, p, y};
    endfunction

    logic       acc;
    int         in_idx, out_idx;
    logic [4:0] max_lvl;

    initial begin
        rst           = 1'b1;
        flit_in_valid = 1'b0;
        flit_in_data  = 32'h0;
        my_tile_id    = 8'd3;
        spike_ready   = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_ready", 32'(flit_in_ready), 32'd1);
        rst = 1'b0;
        tick();
        check("rst_valid",   32'(spike_valid),   32'd0);
        check("rst_pre_id",  32'(spike_pre_id),  32'd0);
        check("rst_payload", 32'(spike_payload), 32'd0);
        check("rst_drop",    32'(drop_count),    32'd0);
        check("rst_level",   32'(level),         32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_ready2",  32'(flit_in_ready), 32'd1);

        // ---------------- single spike, 1-cycle latency ----------------
        flit_in_valid = 1'b1;
        flit_in_data  = mk(2'b01, 8'd3, 14'd5, 8'hA5);
        tick();
        flit_in_valid = 1'b0;
        check("single_valid",   32'(spike_valid),   32'd1);
        check("single_pre_id",  32'(spike_pre_id),  32'd5);
        check("single_payload", 32'(spike_payload), 32'hA5);
        check("single_level",   32'(level),         32'd1);
        tick();
        check("single_valid_off", 32'(spike_valid), 32'd0);
        check("single_level0",    32'(level),       32'd0);

        // ---------------- backpressure, fill to FIFO_DEPTH+1 ----------------
        spike_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            flit_in_valid = 1'b1;
            flit_in_data  = mk(2'b01, 8'd3, 14'(i), 8'(8'h40 + i));
            check("bp_ready_open", 32'(flit_in_ready), 32'd1);
            tick();
        end
        flit_in_data = mk(2'b01, 8'd3, 14'd9, 8'h49);   // 10th stays offered
        tick();
        tick();
        check("bp_ready_full", 32'(flit_in_ready), 32'd0);
        check("bp_level9",     32'(level),         32'd9);
        check("bp_busy",       32'(busy),          32'd1);
        check("bp_hold_valid", 32'(spike_valid),   32'd1);
        check("bp_hold_pre",   32'(spike_pre_id),  32'd0);
        check("bp_hold_pay",   32'(spike_payload), 32'h40);

        spike_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("bp_drain_valid", 32'(spike_valid),   32'd1);
            check("bp_drain_pre",   32'(spike_pre_id),  32'(c));
            check("bp_drain_pay",   32'(spike_payload), 32'(8'h40 + c));
            acc = flit_in_valid && flit_in_ready;
            tick();
            if (acc) flit_in_valid = 1'b0;
        end
        check("bp_empty_valid", 32'(spike_valid), 32'd0);
        check("bp_empty_level", 32'(level),       32'd0);

        // ---------------- filtering ----------------
        flit_in_valid = 1'b1;
        flit_in_data  = mk(2'b01, 8'd4, 14'd1, 8'h01);      // wrong tile
        tick();
        check("flt_valid_a", 32'(spike_valid), 32'd0);
        flit_in_data  = mk(2'b11, 8'd3, 14'd2, 8'h02);      // reserved type
        tick();
        check("flt_valid_b", 32'(spike_valid), 32'd0);
        flit_in_data  = mk(2'b01, 8'd3, 14'h2001, 8'h03);   // id out of range
        tick();
        check("flt_valid_c", 32'(spike_valid), 32'd0);
        check("flt_drop3",   32'(drop_count),  32'd3);
        flit_in_data  = mk(2'b00, 8'd3, 14'd4, 8'h04);      // NOP
        tick();
        flit_in_valid = 1'b0;
        tick();
        check("flt_nop_drop",  32'(drop_count),  32'd3);
        check("flt_nop_valid", 32'(spike_valid), 32'd0);
        check("flt_level",     32'(level),       32'd0);

        // ---------------- throughput / order with toggling ready ----------------
        in_idx  = 0;
        out_idx = 0;
        max_lvl = '0;
        for (int c = 0; c < 80 && out_idx < 12; c++) begin
            spike_ready = (c % 2 == 0);
            if (in_idx < 12) begin
                flit_in_valid = 1'b1;
                flit_in_data  = mk(2'b01, 8'd3, 14'(100 + in_idx), 8'(in_idx));
            end else begin
                flit_in_valid = 1'b0;
            end
            acc = flit_in_valid && flit_in_ready;
            if (spike_valid && spike_ready) begin
                check("tp_order_pre", 32'(spike_pre_id),  32'(100 + out_idx));
                check("tp_order_pay", 32'(spike_payload), 32'(out_idx));
                out_idx++;
            end
            tick();
            if (acc) in_idx++;
            if (level > max_lvl) max_lvl = level;
        end
        flit_in_valid = 1'b0;
        spike_ready   = 1'b1;
        check("tp_count_out", 32'(out_idx), 32'd12);
        check("tp_max_level", 32'(max_lvl <= 5'd9), 32'd1);
        check("tp_end_level", 32'(level), 32'd0);
        check("tp_end_valid", 32'(spike_valid), 32'd0);

        // ---------------- reset mid-operation ----------------
        spike_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flit_in_valid = 1'b1;
            flit_in_data  = mk(2'b01, 8'd3, 14'(20 + i), 8'(i));
            tick();
        end
        flit_in_valid = 1'b0;
        check("mid_level5", 32'(level), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", 32'(spike_valid),   32'd0);
        check("mid_level", 32'(level),         32'd0);
        check("mid_drop",  32'(drop_count),    32'd0);
        check("mid_busy",  32'(busy),          32'd0);
        check("mid_ready", 32'(flit_in_ready), 32'd1);
        spike_ready   = 1'b1;
        flit_in_valid = 1'b1;
        flit_in_data  = mk(2'b01, 8'd3, 14'd7, 8'h5A);
        tick();
        flit_in_valid = 1'b0;
        check("post_valid", 32'(spike_valid),   32'd1);
        check("post_pre",   32'(spike_pre_id),  32'd7);
        check("post_pay",   32'(spike_payload), 32'h5A);
        tick();
        check("post_valid_off", 32'(spike_valid), 32'd0);

        // ---------------- timestep flits ----------------
        flit_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flit_in_data = mk(2'b10, 8'd3, 14'd0, 8'h00);
            tick();
        end
        flit_in_data = mk(2'b10, 8'd4, 14'd0, 8'h00);       // other tile
        tick();
        flit_in_data = mk(2'b01, 8'd3, 14'd9, 8'h11);
        tick();
        flit_in_valid = 1'b0;
        check("ts_valid", 32'(spike_valid),  32'd1);
        check("ts_pre",   32'(spike_pre_id), 32'd9);
`ifdef KF_SPIKE_EJECT_TSTAMP_EN
        check("ts_payload", 32'(spike_payload), 32'h03);
        check("ts_drop",    32'(drop_count),    32'd1);
`else
        check("ts_payload", 32'(spike_payload), 32'h11);
        check("ts_drop",    32'(drop_count),    32'd0);
`endif
        tick();
        check("ts_valid_off", 32'(spike_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
